// File: rtl/wb_pkg.sv
// Shared widths, grant-state encoding and request bundle for the
// two-master Wishbone interconnect.
package wb_pkg;

  localparam int WB_DW  = 32;
  localparam int WB_AW  = 32;
  localparam int WB_BLW = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } wb_gnt_state_e;

  // Master request bundle at the default widths.
  typedef struct packed {
    logic [WB_DW-1:0]   dat;
    logic [WB_AW-1:0]   adr;
    logic [WB_DW/8-1:0] sel;
    logic [WB_BLW-1:0]  bl;
    logic               bry;
    logic               we;
    logic               cyc;
    logic               stb;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Registered two-requester round-robin arbiter; a grant is held until its
// owner drops the request, then one IDLE cycle precedes the next grant.
//
//   state   | meaning
//   IDLE    | no owner, slave side quiet; pick next owner from req
//   GNT0    | master 0 owns the slave until req[0] falls
//   GNT1    | master 1 owns the slave until req[1] falls
module wb_rr_arb2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last
);

  wb_gnt_state_e state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      gnt   <= 2'b00;
      last  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // On a tie the master that was not granted most recently wins.
          if (req[0] && (!req[1] || last)) begin
            state <= ST_GNT0;
            gnt   <= 2'b01;
          end else if (req[1]) begin
            state <= ST_GNT1;
            gnt   <= 2'b10;
          end
        end
        ST_GNT0: begin
          if (!req[0]) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
            last  <= 1'b0;
          end
        end
        ST_GNT1: begin
          if (!req[1]) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
            last  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_interconnect_2m1s.sv
// Two-master, one-slave Wishbone interconnect: request mux toward the slave
// and response routing back to the granted master only.
module wb_interconnect_2m1s
  import wb_pkg::*;
#(
  parameter int DW  = WB_DW,
  parameter int AW  = WB_AW,
  parameter int BLW = WB_BLW
) (
  input  logic            clk,
  input  logic            reset,

  input  logic [DW-1:0]   m0_wbd_dat_i,
  input  logic [AW-1:0]   m0_wbd_adr_i,
  input  logic [DW/8-1:0] m0_wbd_sel_i,
  input  logic [BLW-1:0]  m0_wbd_bl_i,
  input  logic            m0_wbd_bry_i,
  input  logic            m0_wbd_we_i,
  input  logic            m0_wbd_cyc_i,
  input  logic            m0_wbd_stb_i,
  output logic [DW-1:0]   m0_wbd_dat_o,
  output logic            m0_wbd_ack_o,
  output logic            m0_wbd_lack_o,
  output logic            m0_wbd_err_o,

  input  logic [DW-1:0]   m1_wbd_dat_i,
  input  logic [AW-1:0]   m1_wbd_adr_i,
  input  logic [DW/8-1:0] m1_wbd_sel_i,
  input  logic [BLW-1:0]  m1_wbd_bl_i,
  input  logic            m1_wbd_bry_i,
  input  logic            m1_wbd_we_i,
  input  logic            m1_wbd_cyc_i,
  input  logic            m1_wbd_stb_i,
  output logic [DW-1:0]   m1_wbd_dat_o,
  output logic            m1_wbd_ack_o,
  output logic            m1_wbd_lack_o,
  output logic            m1_wbd_err_o,

  input  logic [DW-1:0]   s_wbd_dat_i,
  input  logic            s_wbd_ack_i,
  input  logic            s_wbd_lack_i,
  output logic [DW-1:0]   s_wbd_dat_o,
  output logic [AW-1:0]   s_wbd_adr_o,
  output logic [DW/8-1:0] s_wbd_sel_o,
  output logic [BLW-1:0]  s_wbd_bl_o,
  output logic            s_wbd_bry_o,
  output logic            s_wbd_we_o,
  output logic            s_wbd_cyc_o,
  output logic            s_wbd_stb_o
);

  // Same layout as wb_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DW-1:0]   dat;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [BLW-1:0]  bl;
    logic            bry;
    logic            we;
    logic            cyc;
    logic            stb;
  } req_t;

  req_t       m0_req;
  req_t       m1_req;
  req_t       s_req;
  logic [1:0] gnt;
  logic       last_unused;

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_wbd_cyc_i, m0_wbd_cyc_i}),
    .gnt   (gnt),
    .last  (last_unused)
  );

  assign m0_req = '{dat: m0_wbd_dat_i, adr: m0_wbd_adr_i, sel: m0_wbd_sel_i,
                    bl: m0_wbd_bl_i, bry: m0_wbd_bry_i, we: m0_wbd_we_i,
                    cyc: m0_wbd_cyc_i, stb: m0_wbd_stb_i};
  assign m1_req = '{dat: m1_wbd_dat_i, adr: m1_wbd_adr_i, sel: m1_wbd_sel_i,
                    bl: m1_wbd_bl_i, bry: m1_wbd_bry_i, we: m1_wbd_we_i,
                    cyc: m1_wbd_cyc_i, stb: m1_wbd_stb_i};

  // Nothing reaches the slave while no grant is held.
  always_comb begin
    s_req = '0;
    if (gnt[0]) begin
      s_req = m0_req;
    end else if (gnt[1]) begin
      s_req = m1_req;
    end
  end

  assign s_wbd_dat_o = s_req.dat;
  assign s_wbd_adr_o = s_req.adr;
  assign s_wbd_sel_o = s_req.sel;
  assign s_wbd_bl_o  = s_req.bl;
  assign s_wbd_bry_o = s_req.bry;
  assign s_wbd_we_o  = s_req.we;
  assign s_wbd_cyc_o = s_req.cyc;
  assign s_wbd_stb_o = s_req.stb;

  // Responses are combinational; a stale slave ack during IDLE goes nowhere.
  assign m0_wbd_dat_o  = gnt[0] ? s_wbd_dat_i  : '0;
  assign m0_wbd_ack_o  = gnt[0] ? s_wbd_ack_i  : 1'b0;
  assign m0_wbd_lack_o = gnt[0] ? s_wbd_lack_i : 1'b0;
  assign m1_wbd_dat_o  = gnt[1] ? s_wbd_dat_i  : '0;
  assign m1_wbd_ack_o  = gnt[1] ? s_wbd_ack_i  : 1'b0;
  assign m1_wbd_lack_o = gnt[1] ? s_wbd_lack_i : 1'b0;

  assign m0_wbd_err_o = 1'b0;
  assign m1_wbd_err_o = 1'b0;

endmodule

// File: tb/tb_wb_interconnect_2m1s.sv
// Scoreboard bench for wb_interconnect_2m1s: directed scenarios followed by
// randomized traffic, checked against an ownership-level reference model.
module tb_wb_interconnect_2m1s;
  import wb_pkg::*;

  typedef struct packed {
    logic [WB_DW-1:0] dat;
    logic             ack;
    logic             lack;
    logic             err;
  } rsp_t;

  typedef struct packed {
    wb_req_t s;
    rsp_t    r0;
    rsp_t    r1;
  } exp_t;

  logic             clk;
  logic             reset;
  wb_req_t          m_req [2];
  logic [WB_DW-1:0] s_dat;
  logic             s_ack;
  logic             s_lack;

  logic [WB_DW-1:0]   m0_dat, m1_dat, so_dat;
  logic               m0_ack, m0_lack, m0_err, m1_ack, m1_lack, m1_err;
  logic [WB_AW-1:0]   so_adr;
  logic [WB_DW/8-1:0] so_sel;
  logic [WB_BLW-1:0]  so_bl;
  logic               so_bry, so_we, so_cyc, so_stb;

  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t sb [$];

  // Reference model: who owns the slave this cycle, who owned it last.
  int   owner = -1;
  int   last_owner = 1;
  bit   model_valid = 0;

  wb_interconnect_2m1s dut (
    .clk           (clk),
    .reset         (reset),
    .m0_wbd_dat_i  (m_req[0].dat),
    .m0_wbd_adr_i  (m_req[0].adr),
    .m0_wbd_sel_i  (m_req[0].sel),
    .m0_wbd_bl_i   (m_req[0].bl),
    .m0_wbd_bry_i  (m_req[0].bry),
    .m0_wbd_we_i   (m_req[0].we),
    .m0_wbd_cyc_i  (m_req[0].cyc),
    .m0_wbd_stb_i  (m_req[0].stb),
    .m0_wbd_dat_o  (m0_dat),
    .m0_wbd_ack_o  (m0_ack),
    .m0_wbd_lack_o (m0_lack),
    .m0_wbd_err_o  (m0_err),
    .m1_wbd_dat_i  (m_req[1].dat),
    .m1_wbd_adr_i  (m_req[1].adr),
    .m1_wbd_sel_i  (m_req[1].sel),
    .m1_wbd_bl_i   (m_req[1].bl),
    .m1_wbd_bry_i  (m_req[1].bry),
    .m1_wbd_we_i   (m_req[1].we),
    .m1_wbd_cyc_i  (m_req[1].cyc),
    .m1_wbd_stb_i  (m_req[1].stb),
    .m1_wbd_dat_o  (m1_dat),
    .m1_wbd_ack_o  (m1_ack),
    .m1_wbd_lack_o (m1_lack),
    .m1_wbd_err_o  (m1_err),
    .s_wbd_dat_i   (s_dat),
    .s_wbd_ack_i   (s_ack),
    .s_wbd_lack_i  (s_lack),
    .s_wbd_dat_o   (so_dat),
    .s_wbd_adr_o   (so_adr),
    .s_wbd_sel_o   (so_sel),
    .s_wbd_bl_o    (so_bl),
    .s_wbd_bry_o   (so_bry),
    .s_wbd_we_o    (so_we),
    .s_wbd_cyc_o   (so_cyc),
    .s_wbd_stb_o   (so_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the current cycle follow directly from ownership.
  task automatic push_exp();
    exp_t e;
    if (!model_valid) return;
    e = '0;
    if (owner == 0) begin
      e.s  = m_req[0];
      e.r0 = '{dat: s_dat, ack: s_ack, lack: s_lack, err: 1'b0};
    end else if (owner == 1) begin
      e.s  = m_req[1];
      e.r1 = '{dat: s_dat, ack: s_ack, lack: s_lack, err: 1'b0};
    end
    sb.push_back(e);
  endtask

  // Ownership after the edge, from the inputs sampled at that edge.
  task automatic update_model();
    if (reset) begin
      owner       = -1;
      last_owner  = 1;
      model_valid = 1;
    end else if (model_valid) begin
      if (owner < 0) begin
        if (m_req[0].cyc && m_req[1].cyc) owner = 1 - last_owner;
        else if (m_req[0].cyc)            owner = 0;
        else if (m_req[1].cyc)            owner = 1;
      end else if (!m_req[owner].cyc) begin
        last_owner = owner;
        owner      = -1;
      end
    end
  endtask

  task automatic run_cycle();
    push_exp();
    @(posedge clk);
    #1;
    update_model();
    cyc_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic set_req(input int n, input logic c, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    m_req[n].cyc = c;
    m_req[n].stb = c;
    m_req[n].we  = w;
    m_req[n].adr = a;
    m_req[n].dat = d;
    m_req[n].sel = 4'hF;
    m_req[n].bl  = 10'd1;
    m_req[n].bry = 1'b1;
  endtask

  task automatic set_slv(input logic a, input logic l, input logic [31:0] d);
    s_ack  = a;
    s_lack = l;
    s_dat  = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.s  = '{dat: so_dat, adr: so_adr, sel: so_sel, bl: so_bl, bry: so_bry,
               we: so_we, cyc: so_cyc, stb: so_stb};
      a.r0 = '{dat: m0_dat, ack: m0_ack, lack: m0_lack, err: m0_err};
      a.r1 = '{dat: m1_dat, ack: m1_ack, lack: m1_lack, err: m1_err};
      checks += 3;
      if (a.s !== e.s) begin
        errors++;
        $display("FAIL slave_req cycle %0d: got %h expected %h", cyc_no, a.s, e.s);
      end
      if (a.r0 !== e.r0) begin
        errors++;
        $display("FAIL m0_rsp cycle %0d: got %h expected %h", cyc_no, a.r0, e.r0);
      end
      if (a.r1 !== e.r1) begin
        errors++;
        $display("FAIL m1_rsp cycle %0d: got %h expected %h", cyc_no, a.r1, e.r1);
      end
    end
  end

  initial begin
    int left [2];
    reset = 1'b1;
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 32'h0, 32'h0);
    set_slv(0, 0, 32'h0);
    @(posedge clk);
    #1;
    update_model();
    run(5);
    reset = 1'b0;

    // m0 read of address 0, slave answers 0x297
    set_req(0, 1, 0, 32'h0, 32'h0);
    run(1);
    set_slv(1, 1, 32'h0000_0297);
    run(1);
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_slv(0, 0, 32'h0);
    run(2);

    // m1 write
    set_req(1, 1, 1, 32'h0000_1000, 32'h0000_0001);
    run(2);
    set_slv(1, 1, 32'hDEAD_0001);
    run(1);
    set_req(1, 0, 0, 32'h0, 32'h0);
    set_slv(0, 0, 32'h0);
    run(2);

    // simultaneous requests straight after reset, then round-robin
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    set_req(0, 1, 0, 32'hA0, 32'h0);
    set_req(1, 1, 1, 32'hB0, 32'h11);
    set_slv(1, 0, 32'h1234_5678);
    run(4);
    set_req(0, 0, 0, 32'h0, 32'h0);
    run(5);
    set_req(1, 0, 0, 32'h0, 32'h0);
    run(1);
    set_req(0, 1, 0, 32'hA4, 32'h0);
    set_req(1, 1, 0, 32'hB4, 32'h0);
    run(3);
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 32'h0, 32'h0);
    set_slv(0, 0, 32'h0);
    run(3);

    // m0 burst of 8 acked beats, m1 requests mid-burst, stale ack in gap
    set_req(0, 1, 0, 32'h200, 32'h0);
    run(1);
    for (int b = 0; b < 8; b++) begin
      if (b == 2) set_req(1, 1, 1, 32'h000B_EEF0, 32'hCAFE);
      m_req[0].adr = 32'h200 + 32'(b * 4);
      set_slv(1, b == 7, 32'h100 + 32'(b));
      run(1);
    end
    set_req(0, 0, 0, 32'h0, 32'h0);
    run(1);
    set_slv(1, 0, 32'h5757_5757);
    run(1);
    set_slv(0, 0, 32'h0);
    run(2);
    set_slv(1, 1, 32'h0000_0042);
    run(3);

    // reset in the middle of an m1 burst
    set_slv(1, 0, 32'h77);
    run(1);
    reset = 1'b1;
    set_req(0, 1, 0, 32'h300, 32'h0);
    run(1);
    reset = 1'b0;
    run(4);
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 32'h0, 32'h0);
    set_slv(0, 0, 32'h0);
    run(3);

    // randomized traffic
    left[0] = 0;
    left[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 2; n++) begin
        if (m_req[n].cyc) begin
          if (left[n] == 0) m_req[n].cyc = 1'b0;
          else left[n]--;
        end else if ($urandom_range(0, 2) == 0) begin
          m_req[n].cyc = 1'b1;
          left[n] = int'($urandom_range(0, 10));
        end
        m_req[n].stb = 1'($urandom_range(0, 1));
        m_req[n].we  = 1'($urandom_range(0, 1));
        m_req[n].bry = 1'($urandom_range(0, 1));
        m_req[n].adr = $urandom;
        m_req[n].dat = $urandom;
        m_req[n].sel = 4'($urandom_range(0, 15));
        m_req[n].bl  = 10'($urandom_range(0, 1023));
      end
      set_slv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_cycle();
    end

    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
